// File: rtl/calc_pkg.sv
// calc_pkg: key codes, PS/2 scan-code constants, frame FSM states and the scan-code decoder.
package calc_pkg;
    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_IDLE  = 4'd14;
    localparam logic [3:0] KEY_ERR   = 4'd15;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} frame_state_t;

    // Main-block digits and keypad digits share each code.
    function automatic logic [3:0] scan_decode(input logic [7:0] sc);
        case (sc)
            8'h45, 8'h70: return 4'd0;
            8'h16, 8'h69: return 4'd1;
            8'h1E, 8'h72: return 4'd2;
            8'h26, 8'h7A: return 4'd3;
            8'h25, 8'h6B: return 4'd4;
            8'h2E, 8'h73: return 4'd5;
            8'h36, 8'h74: return 4'd6;
            8'h3D, 8'h6C: return 4'd7;
            8'h3E, 8'h75: return 4'd8;
            8'h46, 8'h7D: return 4'd9;
            8'h79:        return KEY_PLUS;
            8'h4E, 8'h7B: return KEY_MINUS;
            8'h55, 8'h5A: return KEY_EQ;
            default:      return KEY_ERR;
        endcase
    endfunction
endpackage

// File: rtl/keyb_event_fifo.sv
// keyb_event_fifo: show-ahead event FIFO; a push into a full FIFO without a pop is dropped and sets sticky ovf.
module keyb_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp, r_rp;
    logic             r_ovf;
    logic             w_full, w_pop, w_wr;

    assign o_empty = r_wp == r_rp;
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_wr    = i_push && (!w_full || w_pop);
    assign o_data  = r_mem[r_rp[AW-1:0]];
    assign o_ovf   = r_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (i_push && !w_wr) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/keyb_event_ctrl.sv
// keyb_event_ctrl: PS/2 receiver, make/break/extended sequencing and key-event FIFO.
// Define KEYB_PARITY_CHK_EN to reject frames with bad odd parity.
module keyb_event_ctrl
    import calc_pkg::*;
#(
    parameter int FILTER_LEN  = 6,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyb_clk,
    input  logic       keyb_data,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       ovf,
    output logic       frame_err
);
    localparam int H  = FILTER_LEN / 2;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [FILTER_LEN-1:0] FALL_PAT = {{H{1'b0}}, {H{1'b1}}};

    frame_state_t            r_state, w_next;
    logic [FILTER_LEN-1:0]   r_samp;
    logic [10:0]             r_frame;
    logic [3:0]              r_bit;
    logic [TW-1:0]           r_to;
    logic                    r_brk, r_ext, r_push, r_ferr;
    logic [3:0]              r_code, w_head;
    logic [7:0]              w_byte;
    logic                    w_fall, w_timeout, w_good, w_empty;

    assign w_fall    = r_samp == FALL_PAT;
    assign w_timeout = (r_state == ST_SHIFT) && !w_fall && (r_to == TW'(TIMEOUT_CYC - 1));
    assign w_byte    = r_frame[8:1];
`ifdef KEYB_PARITY_CHK_EN
    assign w_good    = !r_frame[0] && r_frame[10] && (^r_frame[9:1]);
`else
    assign w_good    = !r_frame[0] && r_frame[10];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_fall ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_next = (w_fall && r_bit == 4'd10) ? ST_CHECK : (w_timeout ? ST_IDLE : ST_SHIFT);
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samp  <= '1;
            r_frame <= '0;
            r_bit   <= '0;
            r_to    <= '0;
            r_brk   <= 1'b0;
            r_ext   <= 1'b0;
            r_push  <= 1'b0;
            r_code  <= KEY_IDLE;
            r_ferr  <= 1'b0;
        end else begin
            r_samp <= {keyb_clk, r_samp[FILTER_LEN-1:1]};
            r_push <= 1'b0;
            r_ferr <= 1'b0;
            r_to   <= (r_state != ST_SHIFT || w_fall) ? '0 : r_to + 1'b1;
            if (w_fall && r_state != ST_CHECK) begin
                r_frame <= {keyb_data, r_frame[10:1]};
                r_bit   <= (r_state == ST_IDLE) ? 4'd1 : r_bit + 4'd1;
            end
            if (w_timeout) begin
                r_ferr <= 1'b1;
                r_brk  <= 1'b0;
                r_ext  <= 1'b0;
            end
            if (r_state == ST_CHECK) begin
                if (!w_good) begin
                    r_ferr <= 1'b1;
                    r_brk  <= 1'b0;
                    r_ext  <= 1'b0;
                end else if (w_byte == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else if (w_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else begin
                    // A released key (brk) consumes the byte without an event.
                    r_brk  <= 1'b0;
                    r_ext  <= 1'b0;
                    r_push <= !r_brk;
                    r_code <= r_ext ? ((w_byte == 8'h5A) ? KEY_EQ : KEY_ERR) : scan_decode(w_byte);
                end
            end
        end
    end

    keyb_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_push),
        .i_data  (r_code),
        .i_pop   (key_ready),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_ovf   (ovf)
    );

    assign key_valid = !w_empty;
    assign key_code  = key_valid ? w_head : KEY_IDLE;
    assign frame_err = r_ferr;
endmodule

// File: tb/tb_keyb_event_ctrl.sv
// tb_keyb_event_ctrl: directed PS/2 frames with an expected-event scoreboard queue.
module tb_keyb_event_ctrl;
    localparam int TO   = 300;
    localparam int HALF = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       keyb_clk = 1'b1;
    logic       keyb_data = 1'b1;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready = 1'b0;
    logic       ovf;
    logic       frame_err;

    int         checks = 0;
    int         failures = 0;
    int         exp_q[$];

    keyb_event_ctrl #(.FILTER_LEN(6), .TIMEOUT_CYC(TO), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .keyb_clk  (keyb_clk),
        .keyb_data (keyb_data),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .ovf       (ovf),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    endfunction

    // Returns on the negedge where the last falling keyb_clk edge was driven.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (HALF) @(negedge clk);
                keyb_clk = 1'b1;
            end
            keyb_data = f[i];
            repeat (HALF) @(negedge clk);
            keyb_clk = 1'b0;
        end
    endtask

    task automatic release_clk();
        repeat (HALF) @(negedge clk);
        keyb_clk = 1'b1;
        keyb_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b);
        send_bits(mkframe(b, 1'b0, 1'b0), 11);
        release_clk();
    endtask

    task automatic posedges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int e;
        int n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (!key_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_valid"}, 32'(key_valid), 32'd1);
            chk({tag, "_code"}, 32'(key_code), 32'(e));
            key_ready = 1'b1;
            @(negedge clk);
            key_ready = 1'b0;
        end
        repeat (5) @(negedge clk);
        chk({tag, "_empty"}, 32'(key_valid), 32'd0);
        chk({tag, "_idle_code"}, 32'(key_code), 32'd14);
    endtask

    initial begin
        int n;
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'd14);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 0x16: key_valid must rise exactly at E+3 (6 clk edges after the stop-bit fall).
        exp_q.push_back(1);
        send_bits(mkframe(8'h16, 1'b0, 1'b0), 11);
        posedges(5);
        chk("t1_valid_e2", 32'(key_valid), 32'd0);
        posedges(1);
        chk("t1_valid_e3", 32'(key_valid), 32'd1);
        release_clk();
        drain("t1");

        // Make and break of '+' yield a single event.
        exp_q.push_back(10);
        frame(8'h79); frame(8'hF0); frame(8'h79);
        drain("t2");

        // Extended enter then extended enter release.
        exp_q.push_back(12);
        frame(8'hE0); frame(8'h5A); frame(8'hE0); frame(8'hF0); frame(8'h5A);
        drain("t3");

        // Five events with no consumer: fifth dropped, ovf sticky.
        frame(8'h16); frame(8'h1E); frame(8'h26); frame(8'h25);
        chk("t4_ovf_before", 32'(ovf), 32'd0);
        frame(8'h2E);
        chk("t4_ovf_set", 32'(ovf), 32'd1);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
        drain("t4");
        chk("t4_ovf_sticky", 32'(ovf), 32'd1);

        // 0x45 with a flipped parity bit.
        send_bits(mkframe(8'h45, 1'b1, 1'b0), 11);
`ifdef KEYB_PARITY_CHK_EN
        posedges(4);
        chk("t5_ferr_e1", 32'(frame_err), 32'd0);
        posedges(1);
        chk("t5_ferr_e2", 32'(frame_err), 32'd1);
        posedges(1);
        chk("t5_ferr_e3", 32'(frame_err), 32'd0);
`else
        exp_q.push_back(0);
        posedges(5);
        chk("t5_noferr", 32'(frame_err), 32'd0);
`endif
        release_clk();
        drain("t5");

        // Bad stop bit is a framing error in every build.
        send_bits(mkframe(8'h3E, 1'b0, 1'b1), 11);
        posedges(4);
        chk("t6_ferr_e1", 32'(frame_err), 32'd0);
        posedges(1);
        chk("t6_ferr_e2", 32'(frame_err), 32'd1);
        release_clk();
        drain("t6");

        // Five bits then silence: frame_err after TIMEOUT_CYC, then a clean 0x1E frame.
        send_bits(mkframe(8'h1E, 1'b0, 1'b0), 5);
        n = 0;
        while (!frame_err && n < TO + 100) begin
            if (n == 20) begin
                keyb_clk = 1'b1;
                keyb_data = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("t7_timeout_cycle", 32'(n), 32'(TO + 4));
        posedges(1);
        chk("t7_ferr_pulse_end", 32'(frame_err), 32'd0);
        repeat (HALF) @(negedge clk);
        exp_q.push_back(2);
        frame(8'h1E);
        drain("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keyb_event_ctrl.md
# keyb_event_ctrl

PS/2 keyboard receive controller for the calculator. It samples the keyboard clock/data lines, assembles 11-bit frames and handles the make/break/extended prefix sequencing. It maps each key press to a 4-bit calculator key code and buffers the resulting events in a small FIFO with a valid/ready handshake. It sits between the keyboard pins and the calculator FSM, which consumes one event per handshake.

## Interface
- FILTER_LEN, 6: length of the keyb_clk sample shift register; must be even, ≥ 4.
- TIMEOUT_CYC, 50000: clk cycles without a keyb_clk falling edge, mid-frame, before the frame is aborted.
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- keyb_clk  in  1  raw PS/2 clock.
- keyb_data  in  1  raw PS/2 data.
- key_valid  out  1  FIFO head holds an event.
- key_code  out  4  head event code: 0–9 digits, 10 '+', 11 '-', 12 '=', 15 unrecognised; reads 14 whenever key_valid=0.
- key_ready  in  1  consumer accepts the head event.
- ovf  out  1  sticky flag; set when an event is dropped because the FIFO is full.
- frame_err  out  1  one-cycle pulse on a parity, framing or timeout error.

## Operation
- Edge detect:
  - Each cycle, keyb_clk shifts into the MSB of the sample register.
  - A falling edge is flagged when the register equals FILTER_LEN/2 zeros (newest) over FILTER_LEN/2 ones (oldest).
- Frame FSM states: IDLE, SHIFT, CHECK.
  - IDLE → SHIFT on the first edge; that edge captures bit 0.
  - SHIFT captures keyb_data LSB-first on each edge and counts bits 0..10.
  - The edge that captures bit 10 moves the FSM to CHECK.
  - CHECK lasts one cycle and always returns to IDLE.
- Frame check in CHECK: start bit = 0, stop bit = 1, odd parity over data + parity bit. The parity check applies only with the macro; see Configuration.
- Prefix sequencing on good frames, using flags brk and ext:
  - 0xF0 sets brk. 0xE0 sets ext. Neither prefix produces an event.
  - Data byte with brk=1: discarded; clear both flags.
  - Data byte with ext=1, brk=0: 0x5A → 12; any other byte → 15; clear both flags.
  - Plain byte (no flags set):
    - Digits 0–9: 45/70→0, 16/69→1, 1E/72→2, 26/7A→3, 25/6B→4, 2E/73→5, 36/74→6, 3D/6C→7, 3E/75→8, 46/7D→9.
    - 79→10, 4E/7B→11, 55/5A→12.
    - Any other byte → 15.
- Bad frame or timeout: discard the frame, clear brk/ext, produce no event, pulse frame_err.
- FIFO:
  - Show-ahead; key_valid = not empty.
  - A pop occurs when key_valid && key_ready.
  - Push when full with no pop in the same cycle: the event is dropped and ovf is set.
  - Push and pop in the same cycle while full: both happen and nothing is lost.
  - Push and pop in the same cycle while empty: not possible, since key_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; one extra wrap bit distinguishes full from empty.
- Timeout: in SHIFT, a cycle counter restarts on every edge. When it reaches TIMEOUT_CYC-1, the FSM returns to IDLE and the frame is handled as a bad frame.
- Reset, including mid-frame, clears the FSM, bit counter, flags, FIFO and ovf.

## Timing
- Reset values: key_valid=0, key_code=14, ovf=0, frame_err=0; FSM=IDLE; sample register all ones.
- Stop-bit edge flagged in cycle E:
  - E+1: CHECK.
  - E+2: FIFO write.
  - E+3: key_valid=1 and key_code valid, if the FIFO was empty.
- frame_err pulses in E+2 for a bad frame, or in the cycle after the timeout count is reached.
- After a pop, key_valid/key_code update in the next cycle.
- Back-to-back pops are allowed, one event per cycle.

## Configuration
- KEYB_PARITY_CHK_EN:
  - Defined: the parity bit is checked; a parity error counts as a bad frame.
  - Undefined: the parity bit is ignored; only start/stop/timeout errors raise frame_err.

## Structure
- Package calc_pkg holds:
  - key code constants KEY_PLUS=10, KEY_MINUS=11, KEY_EQ=12, KEY_IDLE=14, KEY_ERR=15;
  - scan-code constants SC_BREAK=8'hF0, SC_EXT=8'hE0;
  - frame FSM state typedef;
  - decode function scan → key code.
- Sub-module keyb_event_fifo: parameterised FIFO with push/pop/full/empty/ovf.

## Test plan
- Frame 0x16 (good parity) → key_valid rises at E+3 with key_code=1; pop with key_ready=1 → key_valid=0, key_code=14.
- Sequence 0x79, F0 79 → exactly one event, code 10.
- Sequence E0 5A, then E0 F0 5A → one event, code 12.
- 5 events with key_ready=0, FIFO_DEPTH=4 → 4 queued, ovf=1; drain returns the first 4 codes in order.
- Frame 0x45 with a flipped parity bit → with macro: no event, frame_err pulse; without macro: code 0.
- 5 bits sent then idle TIMEOUT_CYC cycles → frame_err pulse, FSM IDLE; the following full 0x1E frame → code 2.
